input_vc_buffer_unit: RTL

Input-port front end of the router: one instance per input port, directly upstream of the switch allocator. It buffers incoming flits in per-VC FIFOs and latches the output port from each packet's head flit. It drives the allocator's per-port request and out-port vectors, pops the granted VC's flit into a registered crossbar-side output, and returns one credit per dequeued flit to the upstream router.

---
 rtl/input_vc_buffer_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/input_vc_buffer_unit.sv
// Router input port: per-VC flit FIFOs, per-VC route latch and packet FSM, allocator request
// generation, a registered crossbar-side pop path and credit return.
module input_vc_buffer_unit #(
    parameter int unsigned VC_NUM       = 2,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PORT_W       = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_i,
    input  logic [$clog2(VC_NUM)-1:0]        vc_id_i,
    input  logic [1:0]                       flit_type_i,
    input  logic [PORT_W-1:0]                dest_port_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic [VC_NUM-1:0]                downstream_ok_i,
    input  logic [VC_NUM-1:0]                grant_i,
    output logic [VC_NUM-1:0]                request_o,
    output logic [VC_NUM-1:0][PORT_W-1:0]    out_port_o,
    output logic [VC_NUM-1:0]                credit_o,
    output logic                             valid_o,
    output logic [1:0]                       flit_type_o,
    output logic [DATA_W-1:0]                data_o,
    output logic [PORT_W-1:0]                xb_port_o,
    output logic                             error_o
);

    localparam int unsigned VC_W  = $clog2(VC_NUM);
    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [PTR_W-1:0] PtrMax  = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(BUFFER_DEPTH);

    localparam logic [1:0] TypeHead = 2'b00;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q [VC_NUM];
    state_e state_d [VC_NUM];

    logic [1:0]        type_mem [VC_NUM][BUFFER_DEPTH];
    logic [PORT_W-1:0] port_mem [VC_NUM][BUFFER_DEPTH];
    logic [DATA_W-1:0] data_mem [VC_NUM][BUFFER_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q [VC_NUM];
    logic [PTR_W-1:0] wr_ptr_q [VC_NUM];
    logic [CNT_W-1:0] count_q  [VC_NUM];

    logic [1:0]        front_type [VC_NUM];
    logic [PORT_W-1:0] front_port [VC_NUM];
    logic [DATA_W-1:0] front_data [VC_NUM];

    logic [VC_NUM-1:0] sent_q;
    logic [VC_NUM-1:0] non_empty, full, front_head, front_tail;
    logic [VC_NUM-1:0] write_sel, write_ok, pop_grant, discard, pop, route_latch;
    logic              grant_err, error_set;
    logic [1:0]        sel_type;
    logic [PORT_W-1:0] sel_port;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PtrMax) ? '0 : p + 1'b1;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) state_q[v] <= StIdle;
        end else begin
            for (int v = 0; v < VC_NUM; v++) state_q[v] <= state_d[v];
        end
    end

    // FSM next state
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            case (state_q[v])
                StIdle:   if (route_latch[v]) state_d[v] = StActive;
                StActive: if (pop_grant[v] && front_tail[v]) state_d[v] = StIdle;
            endcase
        end
    end

    // FSM outputs and pop decode
    always_comb begin
        sel_type = '0;
        sel_port = '0;
        sel_data = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            front_type[v]  = type_mem[v][rd_ptr_q[v]];
            front_port[v]  = port_mem[v][rd_ptr_q[v]];
            front_data[v]  = data_mem[v][rd_ptr_q[v]];
            non_empty[v]   = (count_q[v] != '0);
            full[v]        = (count_q[v] == CntFull);
            // HEAD is 00 and HEADTAIL is 11; TAIL and HEADTAIL share bit 1
            front_head[v]  = (front_type[v][1] == front_type[v][0]);
            front_tail[v]  = front_type[v][1];
            request_o[v]   = (state_q[v] == StActive) && non_empty[v] && downstream_ok_i[v];
            route_latch[v] = (state_q[v] == StIdle) && non_empty[v] && front_head[v];
            discard[v]     = (state_q[v] == StIdle) && non_empty[v] && !front_head[v];
            write_sel[v]   = valid_i && (vc_id_i == VC_W'(v));
        end
        grant_err = ($countones(grant_i) > 1) || ((grant_i & ~request_o) != '0);
        pop_grant = grant_err ? '0 : (grant_i & request_o);
        pop       = pop_grant | discard;
        write_ok  = write_sel & (~full | pop);
        for (int v = 0; v < VC_NUM; v++) begin
            if (pop_grant[v]) begin
                sel_type = front_type[v];
                sel_port = out_port_o[v];
                sel_data = front_data[v];
            end
        end
        // A HEAD popped after the packet's own head means a missing tail upstream
        error_set = grant_err || (|discard) || (|(write_sel & ~write_ok)) ||
                    (|(pop_grant & front_head & ~front_tail & sent_q));
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (write_ok[v]) begin
                type_mem[v][wr_ptr_q[v]] <= flit_type_i;
                port_mem[v][wr_ptr_q[v]] <= dest_port_i;
                data_mem[v][wr_ptr_q[v]] <= data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            sent_q      <= '0;
            out_port_o  <= '0;
            credit_o    <= '0;
            valid_o     <= 1'b0;
            flit_type_o <= '0;
            data_o      <= '0;
            xb_port_o   <= '0;
            error_o     <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (write_ok[v]) wr_ptr_q[v] <= next_ptr(wr_ptr_q[v]);
                if (pop[v]) rd_ptr_q[v] <= next_ptr(rd_ptr_q[v]);
                if (write_ok[v] && !pop[v]) begin
                    count_q[v] <= count_q[v] + 1'b1;
                end else if (!write_ok[v] && pop[v]) begin
                    count_q[v] <= count_q[v] - 1'b1;
                end
                if (route_latch[v]) out_port_o[v] <= front_port[v];
                if (pop_grant[v]) sent_q[v] <= !front_tail[v];
            end
            valid_o  <= |pop_grant;
            credit_o <= pop;
            if (|pop_grant) begin
                flit_type_o <= sel_type;
                data_o      <= sel_data;
                xb_port_o   <= sel_port;
            end
            error_o <= error_o | error_set;
        end
    end

endmodule
